// File: rtl/life_support_unit.sv
// Life-support controller: saturating power/shield/temp/O2 registers driven by a
// mode FSM, with sticky fatal and registered alarm flags for the bridge console.
module life_support_unit #(
  parameter int W          = 8,
  parameter int DMG        = 5,
  parameter int SHIELD_RST = 100,
  parameter int TEMP_FATAL = 100,
  parameter int O2_GRACE   = 4,
  parameter int O2_LOW     = 4,
  parameter int CHG_RATE   = 2,
  parameter int O2_RATE    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] pwr_in,
  input  logic [W-1:0] shield_in,
  input  logic [W-1:0] temp_in,
  input  logic [W-1:0] o2_in,
  input  logic [W-1:0] amb_temp,
  input  logic         chrg,
  input  logic         o2sup,
  input  logic         atk,
  input  logic [1:0]   mode_req,
  output logic [W-1:0] power,
  output logic [W-1:0] shield,
  output logic [W-1:0] temp,
  output logic [W-1:0] o2,
  output logic [2:0]   state,
  output logic         fatal,
  output logic         alarm
);

  localparam int GW = $clog2(O2_GRACE + 1);

  localparam logic [W-1:0]  DMG_W    = W'(DMG);
  localparam logic [W-1:0]  SRST_W   = W'(SHIELD_RST);
  localparam logic [W-1:0]  TFATAL_W = W'(TEMP_FATAL);
  localparam logic [W-1:0]  O2LOW_W  = W'(O2_LOW);
  localparam logic [W-1:0]  CHG_W    = W'(CHG_RATE);
  localparam logic [W-1:0]  O2R_W    = W'(O2_RATE);
  localparam logic [W-1:0]  ONE_W    = W'(1);
  localparam logic [W-1:0]  TWO_W    = W'(2);
  localparam logic [GW-1:0] GRACE_G  = GW'(O2_GRACE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CRUISE  = 3'd1,
    S_DEFENSE = 3'd2,
    S_STEALTH = 3'd3,
    S_LOWPWR  = 3'd4,
    S_DEAD    = 3'd5
  } state_t;

  state_t        cur, n_state;
  logic [GW-1:0] grace, n_grace;
  logic [W-1:0]  n_power, n_shield, n_temp, n_o2;
  logic          n_fatal, n_alarm;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[W] ? {W{1'b1}} : sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? '0 : a - b;
  endfunction

  function automatic logic [W-1:0] step_to(input logic [W-1:0] a, input logic [W-1:0] t);
    if (a < t) return a + ONE_W;
    if (a > t) return a - ONE_W;
    return a;
  endfunction

  assign state = cur;

  // Entering DEAD freezes resources at the values that caused death.
  always_comb begin
    n_state  = cur;
    n_power  = power;
    n_shield = shield;
    n_temp   = temp;
    n_o2     = o2;
    n_grace  = grace;
    n_fatal  = fatal;
    if (cur == S_DEAD) begin
      n_state = S_DEAD;
    end else if (load) begin
      n_power  = pwr_in;
      n_shield = shield_in;
      n_temp   = temp_in;
      n_o2     = o2_in;
      n_grace  = '0;
      n_state  = S_CRUISE;
    end else if (cur != S_IDLE) begin
      if (temp >= TFATAL_W || grace == GRACE_G) begin
        n_state = S_DEAD;
        n_fatal = 1'b1;
      end else begin
        if (chrg)
          n_power = sat_add(power, CHG_W);
        else if (cur == S_CRUISE)
          n_power = sat_sub(power, ONE_W);
        else if (cur == S_DEFENSE || cur == S_STEALTH)
          n_power = sat_sub(power, TWO_W);

        if (atk)
          n_shield = sat_sub(shield, DMG_W);
        else if (cur == S_DEFENSE)
          n_shield = sat_add(shield, ONE_W);
        else
          n_shield = step_to(shield, SRST_W);

        n_temp = (cur == S_STEALTH) ? sat_add(temp, ONE_W) : step_to(temp, amb_temp);
        n_o2   = o2sup ? sat_add(o2, O2R_W) : sat_sub(o2, ONE_W);

        if (o2 == '0 && !o2sup)
          n_grace = (grace == GRACE_G) ? grace : grace + GW'(1);
        else
          n_grace = '0;

        if (power == '0 && !chrg)
          n_state = S_LOWPWR;
        else if (cur == S_LOWPWR)
          n_state = (power != '0) ? S_CRUISE : S_LOWPWR;
        else begin
          case (mode_req)
            2'b01:   n_state = S_DEFENSE;
            2'b10:   n_state = S_STEALTH;
            default: n_state = S_CRUISE;
          endcase
        end
      end
    end
  end

  always_comb begin
    n_alarm = alarm;
    if (n_state != S_DEAD)
      n_alarm = (n_shield == '0) || (n_o2 < O2LOW_W) || (n_power == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur    <= S_IDLE;
      power  <= '0;
      shield <= '0;
      temp   <= '0;
      o2     <= '0;
      grace  <= '0;
      fatal  <= 1'b0;
      alarm  <= 1'b0;
    end else begin
      cur    <= n_state;
      power  <= n_power;
      shield <= n_shield;
      temp   <= n_temp;
      o2     <= n_o2;
      grace  <= n_grace;
      fatal  <= n_fatal;
      alarm  <= n_alarm;
    end
  end

endmodule
